// File: rtl/companion_pkg.sv
// rtl/companion_pkg.sv - shared animation codes, action codes and arbiter state enum
package companion_pkg;

    localparam logic [2:0] ANIM_NONE   = 3'd0;
    localparam logic [2:0] ANIM_FEED   = 3'd1;
    localparam logic [2:0] ANIM_PLAY   = 3'd2;
    localparam logic [2:0] ANIM_CLEAN  = 3'd3;
    localparam logic [2:0] ANIM_HUNGER = 3'd4;
    localparam logic [2:0] ANIM_HEALTH = 3'd5;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_FEED  = 2'b01;
    localparam logic [1:0] ACT_PLAY  = 2'b10;
    localparam logic [1:0] ACT_CLEAN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    function automatic logic [2:0] action_to_anim(input logic [1:0] act);
        case (act)
            ACT_FEED:  return ANIM_FEED;
            ACT_PLAY:  return ANIM_PLAY;
            ACT_CLEAN: return ANIM_CLEAN;
            default:   return ANIM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/companion_anim_timer.sv
// rtl/companion_anim_timer.sv - loadable down-counter timing one animation
module companion_anim_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (count && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/companion_action_arbiter.sv
// rtl/companion_action_arbiter.sv - arbitrates user actions and stat alerts into animations
// Alert latching is built only when COMPANION_ALERT_EN is defined.
module companion_action_arbiter
    import companion_pkg::*;
#(
    parameter int CLOCK_FREQ   = 125_000_000,
    parameter int ANIM_CYCLES  = CLOCK_FREQ / 2,
    parameter int ALERT_THRESH = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec,
    input  logic [1:0]  selected,
    input  logic [31:0] hunger,
    input  logic [31:0] health,
    output logic        anim_start,
    output logic [2:0]  anim_id,
    output logic        anim_busy,
    output logic        exec_status,
    output logic        alert_pending
);

    localparam int               CNT_W    = $clog2(ANIM_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ANIM_CYCLES - 1);

    state_t     state, state_next;
    logic       exec_v;
    logic       slot_valid;
    logic [1:0] slot_sel;
    logic       user_req;
    logic [1:0] user_sel;
    logic       start;
    logic       win_user;
    logic [2:0] win_id;
    logic [2:0] anim_id_q;
    logic       cur_user;
    logic       timer_done;
    logic       health_pend;
    logic       hunger_pend;

    assign exec_v   = exec && (selected != ACT_NONE);
    // A latched request is older than one arriving now, so it is served first.
    assign user_req = slot_valid || exec_v;
    assign user_sel = slot_valid ? slot_sel : selected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        win_user    = 1'b0;
        win_id      = ANIM_NONE;
        anim_busy   = 1'b0;
        exec_status = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    if (user_req) begin
                        start    = 1'b1;
                        win_user = 1'b1;
                        win_id   = action_to_anim(user_sel);
                    end else if (health_pend) begin
                        start  = 1'b1;
                        win_id = ANIM_HEALTH;
                    end else if (hunger_pend) begin
                        start  = 1'b1;
                        win_id = ANIM_HUNGER;
                    end
                end
                if (start) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                anim_busy = 1'b1;
                if (timer_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                exec_status = cur_user && !rst;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign anim_start = start;
    assign anim_id    = start ? win_id : anim_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            anim_id_q  <= ANIM_NONE;
            cur_user   <= 1'b0;
            slot_valid <= 1'b0;
            slot_sel   <= ACT_NONE;
        end else begin
            if (start) begin
                anim_id_q <= win_id;
                cur_user  <= win_user;
            end
            if (state == ST_IDLE) begin
                // Slot drains here; a fresh exec only stays latched if the slot won this cycle.
                slot_valid <= slot_valid && exec_v;
                slot_sel   <= selected;
            end else if (exec_v && !slot_valid) begin
                slot_valid <= 1'b1;
                slot_sel   <= selected;
            end
        end
    end

    companion_anim_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .load_value(LOAD_VAL),
        .count     (state == ST_PLAY),
        .done      (timer_done)
    );

`ifdef COMPANION_ALERT_EN
    localparam logic [31:0] THRESH = 32'(ALERT_THRESH);

    logic [31:0] prev_health, prev_hunger;
    logic        health_cross, hunger_cross;

    assign health_cross = (health < THRESH) && (prev_health >= THRESH);
    assign hunger_cross = (hunger < THRESH) && (prev_hunger >= THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_health <= THRESH;
            prev_hunger <= THRESH;
            health_pend <= 1'b0;
            hunger_pend <= 1'b0;
        end else begin
            prev_health <= health;
            prev_hunger <= hunger;
            health_pend <= health_cross || (health_pend && !(start && win_id == ANIM_HEALTH));
            hunger_pend <= hunger_cross || (hunger_pend && !(start && win_id == ANIM_HUNGER));
        end
    end

    assign alert_pending = health_pend || hunger_pend;
`else
    logic unused_stats;

    assign health_pend   = 1'b0;
    assign hunger_pend   = 1'b0;
    assign alert_pending = 1'b0;
    assign unused_stats  = ^{hunger, health, 32'(ALERT_THRESH)};
`endif

endmodule

// File: tb/tb_companion_action_arbiter.sv
// tb/tb_companion_action_arbiter.sv - scoreboard bench for companion_action_arbiter
module tb_companion_action_arbiter;

    localparam int ANIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec = 1'b0;
    logic [1:0]  selected = 2'b00;
    logic [31:0] hunger = 32'd50;
    logic [31:0] health = 32'd50;
    logic        anim_start, anim_busy, exec_status, alert_pending;
    logic [2:0]  anim_id;

    always #5 clk = ~clk;

    companion_action_arbiter #(
        .CLOCK_FREQ  (1000),
        .ANIM_CYCLES (ANIM),
        .ALERT_THRESH(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exec         (exec),
        .selected     (selected),
        .hunger       (hunger),
        .health       (health),
        .anim_start   (anim_start),
        .anim_id      (anim_id),
        .anim_busy    (anim_busy),
        .exec_status  (exec_status),
        .alert_pending(alert_pending)
    );

    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         stat_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] obs_id_q[$];
    int         obs_t_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #2;
        if (anim_start === 1'b1) begin
            obs_id_q.push_back(anim_id);
            obs_t_q.push_back(cyc);
        end
        if (exec_status === 1'b1) stat_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 100 && obs_id_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; exec = 1'b1; selected = 2'b01;
        tick(2);
        #1;
        total++; if (anim_start !== 1'b0) $display("FAIL reset_start: got %b want 0", anim_start); else passed++;
        total++; if (anim_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", anim_id); else passed++;
        total++; if (anim_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", anim_busy); else passed++;
        total++; if (exec_status !== 1'b0) $display("FAIL reset_status: got %b want 0", exec_status); else passed++;
        total++; if (alert_pending !== 1'b0) $display("FAIL reset_alert: got %b want 0", alert_pending); else passed++;
        exec = 1'b0; selected = 2'b00;
        tick(1);
        rst = 1'b0;
        tick(2);
        total++; if (obs_id_q.size() != 0) $display("FAIL reset_nostart: got %0d starts want 0", obs_id_q.size()); else passed++;
        obs_id_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_feed();
        logic [2:0] e, o;
        @(negedge clk);
        exec = 1'b1; selected = 2'b01; exp_q.push_back(3'd1);
        #1;
        total++; if (anim_start !== 1'b1) $display("FAIL feed_start: got %b want 1", anim_start); else passed++;
        total++; if (anim_id !== 3'd1) $display("FAIL feed_id: got %0d want 1", anim_id); else passed++;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exec = 1'b0; selected = 2'b00;
            #1;
            total++; if (anim_busy !== (k <= ANIM)) $display("FAIL feed_busy k=%0d: got %b want %b", k, anim_busy, k <= ANIM); else passed++;
            total++; if (exec_status !== (k == ANIM + 1)) $display("FAIL feed_status k=%0d: got %b want %b", k, exec_status, k == ANIM + 1); else passed++;
            total++; if (anim_start !== 1'b0) $display("FAIL feed_restart k=%0d: got %b want 0", k, anim_start); else passed++;
        end
        total++; if (anim_id !== 3'd1) $display("FAIL feed_hold: got %0d want 1", anim_id); else passed++;
        tick(2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_id_q.size() == 0) $display("FAIL feed_sb: got no start want id %0d", e);
            else begin
                o = obs_id_q.pop_front(); void'(obs_t_q.pop_front());
                if (o !== e) $display("FAIL feed_sb: got id %0d want %0d", o, e); else passed++;
            end
        end
        total++; if (obs_id_q.size() != 0) $display("FAIL feed_extra: got %0d extra starts want 0", obs_id_q.size()); else passed++;
        obs_id_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_back_to_back();
        int s0, t0, t1;
        logic [2:0] e, o;
        s0 = stat_cnt;
        @(negedge clk); exec = 1'b1; selected = 2'b01; exp_q.push_back(3'd1);
        @(negedge clk); selected = 2'b10; exp_q.push_back(3'd2);
        @(negedge clk); selected = 2'b11;
        @(negedge clk); exec = 1'b0; selected = 2'b00;
        wait_starts(2);
        tick(20);
        total++;
        if (obs_t_q.size() < 2) $display("FAIL b2b_count: got %0d starts want 2", obs_t_q.size());
        else begin
            t0 = obs_t_q[0]; t1 = obs_t_q[1];
            if (t1 - t0 !== ANIM + 2) $display("FAIL b2b_gap: got %0d cycles want %0d", t1 - t0, ANIM + 2); else passed++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_id_q.size() == 0) $display("FAIL b2b_sb: got no start want id %0d", e);
            else begin
                o = obs_id_q.pop_front(); void'(obs_t_q.pop_front());
                if (o !== e) $display("FAIL b2b_sb: got id %0d want %0d", o, e); else passed++;
            end
        end
        total++; if (obs_id_q.size() != 0) $display("FAIL b2b_dropped: got %0d extra starts want 0", obs_id_q.size()); else passed++;
        total++; if (stat_cnt - s0 !== 2) $display("FAIL b2b_status: got %0d pulses want 2", stat_cnt - s0); else passed++;
        obs_id_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_reset_mid();
        int s0;
        logic [2:0] e, o;
        s0 = stat_cnt;
        @(negedge clk); exec = 1'b1; selected = 2'b01; exp_q.push_back(3'd1);
        @(negedge clk); selected = 2'b10;
        @(negedge clk); exec = 1'b0; selected = 2'b00; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (anim_start !== 1'b0) $display("FAIL rmid_start: got %b want 0", anim_start); else passed++;
        total++; if (anim_id !== 3'd0) $display("FAIL rmid_id: got %0d want 0", anim_id); else passed++;
        total++; if (anim_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", anim_busy); else passed++;
        total++; if (exec_status !== 1'b0) $display("FAIL rmid_status: got %b want 0", exec_status); else passed++;
        tick(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_id_q.size() == 0) $display("FAIL rmid_sb: got no start want id %0d", e);
            else begin
                o = obs_id_q.pop_front(); void'(obs_t_q.pop_front());
                if (o !== e) $display("FAIL rmid_sb: got id %0d want %0d", o, e); else passed++;
            end
        end
        total++; if (obs_id_q.size() != 0) $display("FAIL rmid_slot: got %0d extra starts want 0", obs_id_q.size()); else passed++;
        total++; if (stat_cnt - s0 !== 0) $display("FAIL rmid_pulses: got %0d want 0", stat_cnt - s0); else passed++;
        obs_id_q.delete(); obs_t_q.delete();
    endtask

`ifdef COMPANION_ALERT_EN
    task automatic test_alerts();
        int s0;
        logic [2:0] e, o;
        s0 = stat_cnt;
        @(negedge clk); health = 32'd25; hunger = 32'd30;
        @(negedge clk); health = 32'd15; hunger = 32'd10;
        exp_q.push_back(3'd5); exp_q.push_back(3'd4);
        tick(3);
        #1;
        total++; if (alert_pending !== 1'b1) $display("FAIL alert_pend_mid: got %b want 1", alert_pending); else passed++;
        wait_starts(2);
        tick(8);
        #1;
        total++; if (alert_pending !== 1'b0) $display("FAIL alert_pend_clr: got %b want 0", alert_pending); else passed++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_id_q.size() == 0) $display("FAIL alert_sb: got no start want id %0d", e);
            else begin
                o = obs_id_q.pop_front(); void'(obs_t_q.pop_front());
                if (o !== e) $display("FAIL alert_sb: got id %0d want %0d", o, e); else passed++;
            end
        end
        total++; if (stat_cnt - s0 !== 0) $display("FAIL alert_status: got %0d pulses want 0", stat_cnt - s0); else passed++;
        health = 32'd50; hunger = 32'd50;
        tick(2);
        obs_id_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_user_vs_alert();
        int s0;
        logic [2:0] e, o;
        s0 = stat_cnt;
        @(negedge clk); health = 32'd25;
        @(negedge clk); health = 32'd15;
        @(negedge clk); exec = 1'b1; selected = 2'b01;
        exp_q.push_back(3'd1); exp_q.push_back(3'd5);
        #1;
        total++; if (alert_pending !== 1'b1) $display("FAIL uva_pend: got %b want 1", alert_pending); else passed++;
        @(negedge clk); exec = 1'b0; selected = 2'b00;
        wait_starts(2);
        tick(8);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_id_q.size() == 0) $display("FAIL uva_sb: got no start want id %0d", e);
            else begin
                o = obs_id_q.pop_front(); void'(obs_t_q.pop_front());
                if (o !== e) $display("FAIL uva_sb: got id %0d want %0d", o, e); else passed++;
            end
        end
        total++; if (stat_cnt - s0 !== 1) $display("FAIL uva_status: got %0d pulses want 1", stat_cnt - s0); else passed++;
        health = 32'd50;
        tick(2);
        obs_id_q.delete(); obs_t_q.delete();
    endtask
`else
    task automatic test_no_alert();
        int seen;
        seen = 0;
        @(negedge clk); health = 32'd25;
        @(negedge clk); health = 32'd15;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (alert_pending !== 1'b0) seen++;
        end
        total++; if (seen != 0) $display("FAIL noalert_pend: got %0d high cycles want 0", seen); else passed++;
        total++; if (obs_id_q.size() != 0) $display("FAIL noalert_start: got %0d starts want 0", obs_id_q.size()); else passed++;
        health = 32'd50;
        tick(2);
        obs_id_q.delete(); obs_t_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_feed();
        test_back_to_back();
`ifdef COMPANION_ALERT_EN
        test_alerts();
        test_user_vs_alert();
`else
        test_no_alert();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
